// File: rtl/sr_debug_ctrl.sv
// sr_debug_ctrl: host-side debug controller for a small CPU.
// Accepts RUN/HALT/STEP/DUMP commands, gates CPU advance, single-steps,
// streams the 32 debug registers out on a valid/ready port and counts
// cycles in which the CPU was allowed to advance.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   cmdValid, cmd         host command (00 RUN, 01 HALT, 10 STEP, 11 DUMP)
//   cmdReady              command accepted when cmdValid & cmdReady
//   cpuEn                 CPU advance enable
//   halted                high in HALT only
//   dbgRegAddr            host debug register address (outside DUMP)
//   regAddr, regData      CPU debug register port (index 0 = PC)
//   dumpValid/Data/Idx/Last, dumpReady   dump stream
//   runCycles             number of edges with cpuEn=1 (wrapping)
module sr_debug_ctrl #(
    parameter bit RESET_HALTED = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmdValid,
    input  logic [1:0]  cmd,
    output logic        cmdReady,
    output logic        cpuEn,
    output logic        halted,
    input  logic [4:0]  dbgRegAddr,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        dumpValid,
    output logic [31:0] dumpData,
    output logic [4:0]  dumpIdx,
    output logic        dumpLast,
    input  logic        dumpReady,
    output logic [31:0] runCycles
);

    localparam int unsigned IDX_W  = 5;
    localparam int unsigned DATA_W = 32;

    localparam logic [1:0] CMD_RUN  = 2'b00;
    localparam logic [1:0] CMD_HALT = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(31);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_STEP,
        ST_DUMP
    } state_e;

    localparam state_e RESET_STATE = RESET_HALTED ? ST_HALT : ST_RUN;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [DATA_W-1:0]  run_cycles_q;

    logic cmd_acc;
    logic in_dump;
    logic beat_acc;

    // State and dump index registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RESET_STATE;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    // Enabled-cycle counter; wraps silently
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cycles_q <= '0;
        end else if (cpuEn) begin
            run_cycles_q <= run_cycles_q + DATA_W'(1);
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cpuEn     = 1'b0;
        cmdReady  = 1'b0;
        halted    = 1'b0;
        in_dump   = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                cpuEn    = 1'b1;
                cmdReady = 1'b1;
            end
            ST_HALT: begin
                cmdReady = 1'b1;
                halted   = 1'b1;
            end
            ST_STEP: begin
                cpuEn = 1'b1;
            end
            ST_DUMP: begin
                in_dump = 1'b1;
            end
            default: ;
        endcase

        cmd_acc  = cmdValid & cmdReady;
        beat_acc = in_dump & dumpReady;

        unique case (state_q)
            ST_RUN: begin
                // STEP while running means "stop here", same as HALT
                if (cmd_acc && (cmd == CMD_HALT || cmd == CMD_STEP)) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (cmd_acc) begin
                    unique case (cmd)
                        CMD_RUN:  state_d = ST_RUN;
                        CMD_STEP: state_d = ST_STEP;
                        CMD_DUMP: begin
                            state_d = ST_DUMP;
                            idx_d   = '0;
                        end
                        default:  state_d = ST_HALT;
                    endcase
                end
            end
            ST_STEP: begin
                state_d = ST_HALT;
            end
            ST_DUMP: begin
                // Index only wraps 31->0 together with leaving DUMP
                if (beat_acc) begin
                    idx_d = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_HALT;
                    end
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    // Debug register port and dump stream
    always_comb begin
        regAddr   = in_dump ? idx_q : dbgRegAddr;
        dumpValid = in_dump;
        dumpData  = in_dump ? regData : '0;
        dumpIdx   = in_dump ? idx_q : '0;
        dumpLast  = in_dump && (idx_q == IDX_LAST);
    end

    assign runCycles = run_cycles_q;

endmodule

// File: tb/tb_sr_debug_ctrl.sv
// Bench for sr_debug_ctrl: table of command vectors with a scoreboard queue,
// plus hand-written dump, reset-abort and counter-wrap sequences.
module tb_sr_debug_ctrl;

    localparam logic [1:0] CMD_RUN  = 2'b00;
    localparam logic [1:0] CMD_HALT = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_DUMP = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmdValid;
    logic [1:0]  cmd;
    logic        dumpReady;
    logic [4:0]  dbgRegAddr;
    logic [31:0] regData;
    logic [31:0] pc;

    logic        cmdReady, cpuEn, halted, dumpValid, dumpLast;
    logic [4:0]  regAddr, dumpIdx;
    logic [31:0] dumpData, runCycles;

    logic        cmdReady1, cpuEn1, halted1, dumpValid1, dumpLast1;
    logic [4:0]  regAddr1, dumpIdx1;
    logic [31:0] dumpData1, runCycles1;
    logic [31:0] regData1;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        v;
        logic [1:0]  c;
        logic        e_en;
        logic        e_halt;
        logic        e_rdy;
        logic [31:0] e_rc;
    } vec_t;

    typedef struct {
        logic        e_en;
        logic        e_halt;
        logic        e_rdy;
        logic [31:0] e_rc;
    } exp_t;

    vec_t vecs[24];
    exp_t sb_q[$];
    int   beat_q[$];
    logic [31:0] rc_exp;

    sr_debug_ctrl #(.RESET_HALTED(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .cmdValid(cmdValid), .cmd(cmd),
        .cmdReady(cmdReady), .cpuEn(cpuEn), .halted(halted),
        .dbgRegAddr(dbgRegAddr), .regAddr(regAddr), .regData(regData),
        .dumpValid(dumpValid), .dumpData(dumpData), .dumpIdx(dumpIdx),
        .dumpLast(dumpLast), .dumpReady(dumpReady), .runCycles(runCycles)
    );

    sr_debug_ctrl #(.RESET_HALTED(1'b0)) dut_run (
        .clk(clk), .rst_n(rst_n), .cmdValid(cmdValid), .cmd(cmd),
        .cmdReady(cmdReady1), .cpuEn(cpuEn1), .halted(halted1),
        .dbgRegAddr(dbgRegAddr), .regAddr(regAddr1), .regData(regData1),
        .dumpValid(dumpValid1), .dumpData(dumpData1), .dumpIdx(dumpIdx1),
        .dumpLast(dumpLast1), .dumpReady(dumpReady), .runCycles(runCycles1)
    );

    always #5 clk = ~clk;

    // Tiny CPU model: PC advances 4 per enabled edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) pc <= 32'h0000_0100;
        else if (cpuEn) pc <= pc + 32'd4;
    end

    function automatic logic [31:0] reg_val(input logic [4:0] a, input logic [31:0] p);
        return (a == 5'd0) ? p : {16'hC0DE, 11'd0, a};
    endfunction

    assign regData  = reg_val(regAddr, pc);
    assign regData1 = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One command cycle: expectation queued at drive, compared after the edge
    task automatic cycle(input logic v, input logic [1:0] c, input logic e_en,
                         input logic e_halt, input logic e_rdy, input logic [31:0] e_rc);
        exp_t e;
        e.e_en = e_en; e.e_halt = e_halt; e.e_rdy = e_rdy; e.e_rc = e_rc;
        sb_q.push_back(e);
        cmdValid = v;
        cmd      = c;
        @(posedge clk);
        @(negedge clk);
        cmdValid = 1'b0;
        e = sb_q.pop_front();
        chk("cpuEn",     32'(cpuEn),    32'(e.e_en));
        chk("halted",    32'(halted),   32'(e.e_halt));
        chk("cmdReady",  32'(cmdReady), 32'(e.e_rdy));
        chk("runCycles", runCycles,     e.e_rc);
        rc_exp = e.e_rc;
    endtask

    // Dump from HALT; pattern 1 drives dumpReady 1-0-0-1; abort_at<0 disables reset abort
    task automatic run_dump(input int pattern, input int abort_at);
        int  cycles;
        bit  done;
        int  e_idx;
        logic rdy;
        cycle(1'b1, CMD_DUMP, 1'b0, 1'b0, 1'b0, rc_exp);
        for (int k = 0; k < 32; k++) beat_q.push_back(k);
        cycles = 0;
        done   = 1'b0;
        for (int n = 0; n < 200 && !done; n++) begin
            rdy = (pattern == 0) ? 1'b1 : ((n % 4) == 0 || (n % 4) == 3);
            dumpReady = rdy;
            #1;
            e_idx = beat_q[0];
            chk("dump_valid", 32'(dumpValid), 32'd1);
            chk("dump_idx",   32'(dumpIdx),   32'(e_idx));
            chk("dump_data",  dumpData,       reg_val(5'(e_idx), pc));
            chk("dump_last",  32'(dumpLast),  32'(e_idx == 31));
            chk("dump_rdy_lo", 32'(cmdReady), 32'd0);
            if (e_idx == abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_valid",  32'(dumpValid), 32'd0);
                chk("abort_halted", 32'(halted),    32'd1);
                chk("abort_idx",    32'(dumpIdx),   32'd0);
                chk("abort_rc",     runCycles,      32'd0);
                beat_q.delete();
                dumpReady = 1'b0;
                @(negedge clk);
                rst_n  = 1'b1;
                rc_exp = 32'd0;
                return;
            end
            @(posedge clk);
            @(negedge clk);
            cycles++;
            if (rdy) begin
                void'(beat_q.pop_front());
                if (e_idx == 31) done = 1'b1;
            end
        end
        dumpReady = 1'b0;
        chk("dump_done", 32'(done), 32'd1);
        chk("dump_beats_left", 32'(beat_q.size()), 32'd0);
        if (pattern == 0) chk("dump_cycles", 32'(cycles), 32'd32);
        else              chk("dump_cycles_stall", 32'(cycles), 32'd64);
        chk("dump_exit_halted", 32'(halted),    32'd1);
        chk("dump_exit_valid",  32'(dumpValid), 32'd0);
        chk("dump_exit_rdy",    32'(cmdReady),  32'd1);
        chk("dump_exit_rc",     runCycles,      rc_exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pc0;
        pc0 = '0;
        rc_exp = '0;
        // Vectors: command driven, expected cpuEn/halted/cmdReady/runCycles after the edge
        vecs[0] = '{1'b1, CMD_RUN, 1'b1, 1'b0, 1'b1, 32'd0};
        for (int i = 1; i <= 10; i++) vecs[i] = '{1'b0, CMD_RUN, 1'b1, 1'b0, 1'b1, 32'(i)};
        vecs[11] = '{1'b1, CMD_DUMP, 1'b1, 1'b0, 1'b1, 32'd11};
        vecs[12] = '{1'b1, CMD_RUN,  1'b1, 1'b0, 1'b1, 32'd12};
        vecs[13] = '{1'b1, CMD_STEP, 1'b0, 1'b1, 1'b1, 32'd13};
        vecs[14] = '{1'b0, CMD_RUN,  1'b0, 1'b1, 1'b1, 32'd13};
        vecs[15] = '{1'b1, CMD_HALT, 1'b0, 1'b1, 1'b1, 32'd13};
        vecs[16] = '{1'b1, CMD_STEP, 1'b1, 1'b0, 1'b0, 32'd13};
        vecs[17] = '{1'b0, CMD_RUN,  1'b0, 1'b1, 1'b1, 32'd14};
        vecs[18] = '{1'b0, CMD_RUN,  1'b0, 1'b1, 1'b1, 32'd14};
        vecs[19] = '{1'b1, CMD_STEP, 1'b1, 1'b0, 1'b0, 32'd14};
        vecs[20] = '{1'b0, CMD_RUN,  1'b0, 1'b1, 1'b1, 32'd15};
        vecs[21] = '{1'b1, CMD_STEP, 1'b1, 1'b0, 1'b0, 32'd15};
        vecs[22] = '{1'b1, CMD_RUN,  1'b0, 1'b1, 1'b1, 32'd16};
        vecs[23] = '{1'b0, CMD_RUN,  1'b0, 1'b1, 1'b1, 32'd16};

        rst_n      = 1'b0;
        cmdValid   = 1'b0;
        cmd        = CMD_RUN;
        dumpReady  = 1'b0;
        dbgRegAddr = 5'd3;
        @(negedge clk);
        @(negedge clk);
        chk("rst_cpuEn",    32'(cpuEn),     32'd0);
        chk("rst_halted",   32'(halted),    32'd1);
        chk("rst_cmdReady", 32'(cmdReady),  32'd1);
        chk("rst_dumpValid",32'(dumpValid), 32'd0);
        chk("rst_dumpLast", 32'(dumpLast),  32'd0);
        chk("rst_dumpIdx",  32'(dumpIdx),   32'd0);
        chk("rst_rc",       runCycles,      32'd0);
        chk("rst_regAddr",  32'(regAddr),   32'd3);
        dbgRegAddr = 5'd7;
        #1;
        chk("regAddr_follow", 32'(regAddr), 32'd7);
        chk("run_rst_cpuEn",    32'(cpuEn1),     32'd1);
        chk("run_rst_halted",   32'(halted1),    32'd0);
        chk("run_rst_cmdReady", 32'(cmdReady1),  32'd1);
        chk("run_rst_dumpValid",32'(dumpValid1), 32'd0);
        chk("run_rst_dumpLast", 32'(dumpLast1),  32'd0);
        chk("run_rst_dumpIdx",  32'(dumpIdx1),   32'd0);
        chk("run_rst_dumpData", dumpData1,       32'd0);
        chk("run_rst_rc",       runCycles1,      32'd0);
        chk("run_rst_regAddr",  32'(regAddr1),   32'd7);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 24; i++) begin
            if (i == 16) pc0 = pc;
            cycle(vecs[i].v, vecs[i].c, vecs[i].e_en, vecs[i].e_halt, vecs[i].e_rdy, vecs[i].e_rc);
            if (i == 0) chk("run_inst_rc", runCycles1, 32'd1);
            if (i == 11) chk("run_dump_ignored", 32'(dumpValid), 32'd0);
        end
        chk("step_pc_adv", pc - pc0, 32'd12);

        run_dump(0, -1);
        run_dump(1, -1);
        run_dump(0, 17);
        chk("post_abort_idx", 32'(dumpIdx), 32'd0);
        run_dump(0, -1);

        // Preload the counter near wrap while halted
        force dut.run_cycles_q = 32'hFFFF_FFFF;
        @(posedge clk);
        @(negedge clk);
        release dut.run_cycles_q;
        #1;
        chk("preload_rc", runCycles, 32'hFFFF_FFFF);
        cycle(1'b1, CMD_RUN,  1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
        cycle(1'b1, CMD_DUMP, 1'b1, 1'b0, 1'b1, 32'd0);
        chk("run_dump_valid", 32'(dumpValid), 32'd0);
        cycle(1'b1, CMD_STEP, 1'b0, 1'b1, 1'b1, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sr_debug_ctrl.md
SR_DEBUG_CTRL -- requirements
Module: sr_debug_ctrl

Interface
REQ-001 SHALL have parameter RESET_HALTED, default 1, meaning that reset enters HALT when 1 and RUN when 0.
REQ-002 SHALL have port clk  input  1  the single clock for all state.
REQ-003 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port cmdValid  input  1  host command valid.
REQ-005 SHALL have port cmd  input  2  host command: 00 RUN, 01 HALT, 10 STEP, 11 DUMP.
REQ-006 SHALL have port cmdReady  output  1  command accepted when cmdValid&cmdReady.
REQ-007 SHALL have port cpuEn  output  1  CPU advance enable (gates PC and register-file write).
REQ-008 SHALL have port halted  output  1  high in HALT state only.
REQ-009 SHALL have port dbgRegAddr  input  5  host debug address, used outside DUMP.
REQ-010 SHALL have port regAddr  output  5  CPU debug register address.
REQ-011 SHALL have port regData  input  32  CPU debug data (index 0 = PC).
REQ-012 SHALL have ports dumpValid  output  1, dumpData  output  32, dumpIdx  output  5, dumpLast  output  1  dump stream.
REQ-013 SHALL have port dumpReady  input  1  dump stream consumer ready.
REQ-014 SHALL have port runCycles  output  32  count of cycles with cpuEn=1.

Function
REQ-015 SHALL implement four states: RUN, HALT, STEP, DUMP.
REQ-016 SHALL drive cpuEn=1 in RUN and STEP, 0 in HALT and DUMP, decoded from the current state.
REQ-017 SHALL drive cmdReady=1 in RUN and HALT, 0 in STEP and DUMP.
REQ-018 RUN: accepted HALT or STEP -> HALT next cycle; RUN and DUMP are accepted and ignored; the edge that ends the acceptance cycle still advances the CPU.
REQ-019 HALT: accepted RUN -> RUN; STEP -> STEP; DUMP -> DUMP with idx=0; HALT is accepted and ignored.
REQ-020 STEP: SHALL last exactly one cycle, so the CPU advances exactly one instruction, then return unconditionally to HALT.
REQ-021 DUMP: regAddr=idx; dumpValid=1; dumpData=regData; dumpIdx=idx; dumpLast=(idx==31).
REQ-022 DUMP: on dumpValid&dumpReady, idx SHALL increment by 1; a handshake with idx==31 SHALL return to HALT next cycle.
REQ-023 DUMP: while dumpReady=0, idx, dumpIdx and dumpData SHALL hold stable, since the CPU is frozen.
REQ-024 DUMP SHALL emit exactly 32 beats, idx 0..31 in order, with no gaps when dumpReady stays high.
REQ-025 Outside DUMP: regAddr=dbgRegAddr (combinational); dumpValid=0; dumpLast=0; dumpIdx=0.
REQ-026 runCycles SHALL increment by 1 on every clock edge where cpuEn=1, wrapping 0xFFFFFFFF->0 with no flag.
REQ-027 idx SHALL be a 5-bit register; the 31->0 wrap SHALL occur only together with the exit from DUMP.
REQ-028 cmd SHALL be sampled only when cmdValid&cmdReady; commands presented while cmdReady=0 SHALL have no effect and are not queued.

Reset
REQ-029 On rst_n low, SHALL asynchronously set state to HALT if RESET_HALTED=1, else RUN.
REQ-030 On rst_n low, SHALL set idx=0 and runCycles=0.
REQ-031 During and after reset: dumpValid=0, dumpLast=0, cmdReady=1, cpuEn=!RESET_HALTED, halted=RESET_HALTED.
REQ-032 Reset asserted mid-DUMP or mid-STEP SHALL abort the operation immediately, with no further dump beats.
REQ-033 Reset release SHALL be synchronous to clk; the first command SHALL be accepted on the first edge after release.

Verification
REQ-034 Reset with RESET_HALTED=1, then cmd RUN for 1 cycle and hold 10 cycles -> cpuEn=1 from the cycle after acceptance; runCycles=10 after 10 edges.
REQ-035 In HALT, issue STEP 3 times with gaps -> cpuEn high for exactly 3 single cycles; PC advances 12; runCycles=3; halted=1 at the end.
REQ-036 In HALT, DUMP with dumpReady=1 -> 32 consecutive beats, dumpIdx 0..31, beat 0 data=PC, dumpLast only on beat 31; HALT on the next cycle; cmdReady low throughout.
REQ-037 DUMP with dumpReady toggling 1-0-0-1 -> no beat lost or repeated; dumpData and dumpIdx stable while stalled.
REQ-038 rst_n pulsed low at dump beat 17 -> dumpValid=0 immediately; state HALT; idx=0; runCycles=0.
REQ-039 In RUN, issue DUMP then STEP -> DUMP ignored (state RUN, dumpValid=0); STEP yields HALT; runCycles preloaded to 0xFFFFFFFF wraps to 0 on the next enabled edge.
